// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised register file with one write port and two
// registered read ports. Reads are write-first (same-edge write data is
// forwarded). A pending bit per register tracks in-flight multi-cycle
// producers. With ZERO_R0=1, register 0 is hardwired to zero.
module regfile_2r1w #(
   parameter int WIDTH   = 16,
   parameter int ADDR_W  = 3,
   parameter int ZERO_R0 = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [WIDTH-1:0]  data_in,
   input  logic [ADDR_W-1:0] writenum,
   input  logic              write,
   input  logic [ADDR_W-1:0] readnum_a,
   input  logic [ADDR_W-1:0] readnum_b,
   input  logic              claim,
   input  logic [ADDR_W-1:0] claimnum,
   output logic [WIDTH-1:0]  data_out_a,
   output logic [WIDTH-1:0]  data_out_b,
   output logic              busy_a,
   output logic              busy_b,
   output logic              any_pending
);

   localparam int unsigned NREGS  = 2 ** ADDR_W;
   localparam bit          ZERO_EN = (ZERO_R0 != 0);

   logic [WIDTH-1:0] regs [NREGS];
   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] next_pending;
   logic             wr_en;
   logic             zero_a;
   logic             zero_b;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;

   // A write to the hardwired zero register is dropped entirely.
   assign wr_en  = write && !(ZERO_EN && (writenum == '0));
   assign zero_a = ZERO_EN && (readnum_a == '0);
   assign zero_b = ZERO_EN && (readnum_b == '0);

   // Scoreboard next state: write clears, claim sets afterwards so it wins.
   always_comb begin
      next_pending = pending;
      if (write)
         next_pending[writenum] = 1'b0;
      if (claim)
         next_pending[claimnum] = 1'b1;
      if (ZERO_EN)
         next_pending[0] = 1'b0;
   end

   // Read mux per port: zero-forced, then forwarded write data, then array.
   always_comb begin
      rd_a = regs[readnum_a];
      rd_b = regs[readnum_b];
      if (wr_en && (readnum_a == writenum))
         rd_a = data_in;
      if (wr_en && (readnum_b == writenum))
         rd_b = data_in;
      if (zero_a)
         rd_a = '0;
      if (zero_b)
         rd_b = '0;
   end

   // Register array, scoreboard and registered read outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NREGS; i++)
            regs[i] <= '0;
         pending    <= '0;
         data_out_a <= '0;
         data_out_b <= '0;
         busy_a     <= 1'b0;
         busy_b     <= 1'b0;
      end else begin
         if (wr_en)
            regs[writenum] <= data_in;
         pending    <= next_pending;
         data_out_a <= rd_a;
         data_out_b <= rd_b;
         busy_a     <= next_pending[readnum_a];
         busy_b     <= next_pending[readnum_b];
      end
   end

   // Live view of the scoreboard, not registered.
   assign any_pending = |pending;

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: table-driven and randomized checks of regfile_2r1w in
// three configurations (default, ZERO_R0=1, WIDTH=32/ADDR_W=4).
module tb_regfile_2r1w;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // shared stimulus for the two 16-bit/8-register instances
   logic        rst_n = 1'b0;
   logic        wr = 1'b0;
   logic [2:0]  wa = '0;
   logic [15:0] din = '0;
   logic [2:0]  ra = '0;
   logic [2:0]  rb = '0;
   logic        cl = 1'b0;
   logic [2:0]  cn = '0;

   logic [15:0] a0, b0, a1, b1;
   logic        ba0, bb0, ap0, ba1, bb1, ap1;

   // stimulus for the 32-bit/16-register instance
   logic        r2 = 1'b0;
   logic        w2 = 1'b0;
   logic [3:0]  wa2 = '0;
   logic [31:0] din2 = '0;
   logic [3:0]  ra2 = '0;
   logic [3:0]  rb2 = '0;
   logic        cl2 = 1'b0;
   logic [3:0]  cn2 = '0;
   logic [31:0] a2, b2;
   logic        ba2, bb2, ap2;

   int total = 0;
   int bad = 0;

   regfile_2r1w #(.WIDTH(16), .ADDR_W(3), .ZERO_R0(0)) dut0 (
      .clk(clk), .reset_n(rst_n), .data_in(din), .writenum(wa), .write(wr),
      .readnum_a(ra), .readnum_b(rb), .claim(cl), .claimnum(cn),
      .data_out_a(a0), .data_out_b(b0), .busy_a(ba0), .busy_b(bb0),
      .any_pending(ap0));

   regfile_2r1w #(.WIDTH(16), .ADDR_W(3), .ZERO_R0(1)) dut1 (
      .clk(clk), .reset_n(rst_n), .data_in(din), .writenum(wa), .write(wr),
      .readnum_a(ra), .readnum_b(rb), .claim(cl), .claimnum(cn),
      .data_out_a(a1), .data_out_b(b1), .busy_a(ba1), .busy_b(bb1),
      .any_pending(ap1));

   regfile_2r1w #(.WIDTH(32), .ADDR_W(4), .ZERO_R0(0)) dut2 (
      .clk(clk), .reset_n(r2), .data_in(din2), .writenum(wa2), .write(w2),
      .readnum_a(ra2), .readnum_b(rb2), .claim(cl2), .claimnum(cn2),
      .data_out_a(a2), .data_out_b(b2), .busy_a(ba2), .busy_b(bb2),
      .any_pending(ap2));

   // Reference model: memory and pending set per configuration (index = zero mode).
   logic [15:0] m_mem  [2][8];
   bit          m_pend [2][8];
   logic [15:0] e_a [2];
   logic [15:0] e_b [2];
   bit          e_ba [2];
   bit          e_bb [2];
   bit          e_any [2];

   // Write-first is modelled by applying the write to memory and then reading it.
   task automatic model_edge(input int z);
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            m_mem[z][i]  = '0;
            m_pend[z][i] = 0;
         end
      end else begin
         if (wr) begin
            m_pend[z][wa] = 0;
            if (!(z == 1 && wa == 0))
               m_mem[z][wa] = din;
         end
         if (cl && !(z == 1 && cn == 0))
            m_pend[z][cn] = 1;
      end
      e_a[z]  = rst_n ? m_mem[z][ra] : 16'h0;
      e_b[z]  = rst_n ? m_mem[z][rb] : 16'h0;
      e_ba[z] = rst_n ? m_pend[z][ra] : 0;
      e_bb[z] = rst_n ? m_pend[z][rb] : 0;
      e_any[z] = 0;
      for (int i = 0; i < 8; i++)
         if (m_pend[z][i]) e_any[z] = 1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock edge for dut0/dut1, checked against the model #1 after the edge.
   task automatic step();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      chk("m0.a", a0, e_a[0]);     chk("m0.b", b0, e_b[0]);
      chk("m0.busy_a", ba0, e_ba[0]); chk("m0.busy_b", bb0, e_bb[0]);
      chk("m0.any", ap0, e_any[0]);
      chk("m1.a", a1, e_a[1]);     chk("m1.b", b1, e_b[1]);
      chk("m1.busy_a", ba1, e_ba[1]); chk("m1.busy_b", bb1, e_bb[1]);
      chk("m1.any", ap1, e_any[1]);
   endtask

   task automatic step2();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        rst_n;
      logic        wr;
      logic [2:0]  wa;
      logic [15:0] din;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic        cl;
      logic [2:0]  cn;
      logic [15:0] ea;
      logic [15:0] eb;
      logic        eba;
      logic        ebb;
      logic        eany;
   } vec_t;

   vec_t tbl [20];

   initial begin
      //          rst wr wa din      ra rb cl cn  ea       eb       ba bb any
      tbl[0]  = '{0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};
      tbl[1]  = '{1, 1, 3, 16'h00A5, 3, 7, 0, 0, 16'h00A5, 16'h0000, 0, 0, 0};
      tbl[2]  = '{0, 1, 3, 16'h1111, 3, 7, 1, 2, 16'h0000, 16'h0000, 0, 0, 0};
      tbl[3]  = '{1, 0, 0, 16'h0000, 3, 7, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};
      tbl[4]  = '{1, 1, 2, 16'h1234, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};
      tbl[5]  = '{1, 1, 5, 16'hBEEF, 2, 5, 0, 0, 16'h1234, 16'hBEEF, 0, 0, 0};
      tbl[6]  = '{1, 0, 0, 16'h0000, 5, 5, 0, 0, 16'hBEEF, 16'hBEEF, 0, 0, 0};
      tbl[7]  = '{1, 1, 4, 16'h0001, 4, 2, 0, 0, 16'h0001, 16'h1234, 0, 0, 0};
      tbl[8]  = '{1, 1, 4, 16'h7777, 4, 4, 0, 0, 16'h7777, 16'h7777, 0, 0, 0};
      tbl[9]  = '{1, 0, 0, 16'h0000, 4, 4, 0, 0, 16'h7777, 16'h7777, 0, 0, 0};
      tbl[10] = '{1, 0, 0, 16'h0000, 6, 4, 1, 6, 16'h0000, 16'h7777, 1, 0, 1};
      tbl[11] = '{1, 0, 0, 16'h0000, 6, 4, 0, 0, 16'h0000, 16'h7777, 1, 0, 1};
      tbl[12] = '{1, 1, 6, 16'h00FF, 6, 6, 0, 0, 16'h00FF, 16'h00FF, 0, 0, 0};
      tbl[13] = '{1, 1, 1, 16'hABCD, 1, 6, 1, 1, 16'hABCD, 16'h00FF, 1, 0, 1};
      tbl[14] = '{1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'hABCD, 16'hABCD, 1, 1, 1};
      tbl[15] = '{1, 0, 0, 16'h0000, 1, 2, 1, 1, 16'hABCD, 16'h1234, 1, 0, 1};
      tbl[16] = '{1, 1, 7, 16'h5555, 1, 7, 0, 0, 16'hABCD, 16'h5555, 1, 0, 1};
      tbl[17] = '{1, 0, 0, 16'h0000, 3, 1, 1, 3, 16'h0000, 16'hABCD, 1, 1, 1};
      tbl[18] = '{0, 0, 0, 16'h0000, 1, 3, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};
      tbl[19] = '{1, 0, 0, 16'h0000, 1, 6, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};

      // Directed table on the default configuration.
      for (int i = 0; i < 20; i++) begin
         rst_n = tbl[i].rst_n; wr = tbl[i].wr; wa = tbl[i].wa; din = tbl[i].din;
         ra = tbl[i].ra; rb = tbl[i].rb; cl = tbl[i].cl; cn = tbl[i].cn;
         step();
         chk($sformatf("tbl%0d.a", i), a0, tbl[i].ea);
         chk($sformatf("tbl%0d.b", i), b0, tbl[i].eb);
         chk($sformatf("tbl%0d.busy_a", i), ba0, tbl[i].eba);
         chk($sformatf("tbl%0d.busy_b", i), bb0, tbl[i].ebb);
         chk($sformatf("tbl%0d.any", i), ap0, tbl[i].eany);
      end

      // Hardwired R0: write FFFF to R0 while reading it.
      rst_n = 1; wr = 1; wa = 0; din = 16'hFFFF; ra = 0; rb = 0; cl = 0; cn = 0;
      step();
      chk("z.same_cycle_a", a1, 16'h0000);
      chk("z.same_cycle_b", b1, 16'h0000);
      chk("z.normal_fwd", a0, 16'hFFFF);
      wr = 0;
      step();
      chk("z.later_a", a1, 16'h0000);
      chk("z.normal_kept", a0, 16'hFFFF);
      cl = 1; cn = 0;
      step();
      chk("z.claim_any", ap1, 1'b0);
      chk("z.claim_busy", ba1, 1'b0);
      chk("z.normal_claim_any", ap0, 1'b1);
      cl = 0; wr = 1; wa = 1; din = 16'h4242; ra = 1;
      step();
      chk("z.r1_write", a1, 16'h4242);

      // Randomized traffic on both 8-register configurations.
      for (int n = 0; n < 400; n++) begin
         rst_n = ($urandom_range(0, 39) != 0);
         wr  = $urandom_range(0, 1);
         wa  = 3'($urandom);
         din = 16'($urandom);
         ra  = 3'($urandom);
         rb  = ($urandom_range(0, 3) == 0) ? ra : 3'($urandom);
         cl  = ($urandom_range(0, 2) == 0);
         cn  = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom);
         step();
      end

      // Wide configuration: reset, R15 write, then sweep R0..R14.
      step2();
      chk("w.reset_a", a2, 32'h0);
      chk("w.reset_any", ap2, 1'b0);
      r2 = 1; w2 = 1; wa2 = 15; din2 = 32'hDEADBEEF; ra2 = 15; rb2 = 15;
      step2();
      chk("w.fwd_b", b2, 32'hDEADBEEF);
      w2 = 0;
      for (int i = 0; i < 15; i++) begin
         ra2 = 4'(i); rb2 = 15;
         step2();
         chk($sformatf("w.r%0d_zero", i), a2, 32'h0);
         chk("w.r15_b", b2, 32'hDEADBEEF);
      end
      cl2 = 1; cn2 = 9; ra2 = 9; rb2 = 15;
      step2();
      chk("w.busy_a", ba2, 1'b1);
      chk("w.busy_b", bb2, 1'b0);
      chk("w.any", ap2, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
